// File: rtl/ev22_pkg.sv
// Shared types and field positions for the EV22 fetch stage.
// Instruction layout: OPCODE in [15:8], reserved [7:5], Ri in [4:0].
package ev22_pkg;

  localparam int EV22_ADDR_W  = 10;
  localparam int EV22_INSTR_W = 16;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 8;
  localparam int RSVD_MSB = 7;
  localparam int RSVD_LSB = 5;
  localparam int RI_MSB   = 4;
  localparam int RI_LSB   = 0;

  localparam int OPC_W  = OPC_MSB - OPC_LSB + 1;
  localparam int RSVD_W = RSVD_MSB - RSVD_LSB + 1;
  localparam int RI_W   = RI_MSB - RI_LSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load (branch) beats increment beats hold; wraps modulo 2^ADDR_W.
// pc_next is the value the register takes at the coming edge, so callers can latch it early.
module pc_counter
  import ev22_pkg::*;
#(
  parameter int              ADDR_W   = EV22_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// EV22 fetch stage: PC + one-outstanding imem req/ack, IR handed to decoder via ir_valid/dec_ready.
// Latency: 1 instruction per L+2 cycles at ack latency L; the IR is held while dec_ready is low.
module fetch_unit
  import ev22_pkg::*;
#(
  parameter int                ADDR_W   = EV22_ADDR_W,
  parameter int                INSTR_W  = EV22_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               dec_ready,
  output logic               ir_valid,
  output logic [OPC_W-1:0]   OPCODE,
  output logic [RI_W-1:0]    Ri,
  output logic [ADDR_W-1:0]  ir_pc
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [ADDR_W-1:0]  fetch_addr_q;
  logic [ADDR_W-1:0]  fetch_addr_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic [ADDR_W-1:0]  ir_pc_d;
  logic [ADDR_W-1:0]  pc_next;

  logic pc_inc;
  logic ir_load;
  logic fetch_load;

  // A branch always retargets the PC, whatever the FSM does with the word in flight.
  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (br_taken),
    .load_val (br_target),
    .inc      (pc_inc),
    .pc_next  (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    fetch_load = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        fetch_load = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          if (br_taken) begin
            // Word arrived for the stale path: drop it and re-issue at the target.
            state_d    = FETCH;
            fetch_load = 1'b1;
          end else begin
            state_d = HOLD;
            ir_load = 1'b1;
            pc_inc  = 1'b1;
          end
        end else if (br_taken) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d    = FETCH;
          fetch_load = 1'b1;
        end
      end
      HOLD: begin
        if (br_taken || dec_ready) begin
          state_d    = FETCH;
          fetch_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_addr_d = fetch_load ? pc_next : fetch_addr_q;
    ir_d         = ir_load ? imem_rdata : ir_q;
    ir_pc_d      = ir_load ? fetch_addr_q : ir_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= '0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
    end
  end

  always_comb begin
    imem_req = (state_q == FETCH) || (state_q == DROP);
    ir_valid = (state_q == HOLD);
  end

  assign imem_addr = fetch_addr_q;
  assign OPCODE    = ir_q[OPC_MSB:OPC_LSB];
  assign Ri        = ir_q[RI_MSB:RI_LSB];
  assign ir_pc     = ir_pc_q;

  logic [RSVD_W-1:0] ir_rsvd_unused;
  assign ir_rsvd_unused = ir_q[RSVD_MSB:RSVD_LSB];

  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  a_no_req_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ir_valid |-> !imem_req);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with programmable ack latency plus a
// scoreboard of expected decoder transfers, checked by a monitor as they happen.
module tb_fetch_unit;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [7:0]        opc;
    logic [4:0]        ri;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               dec_ready;
  logic               ir_valid;
  logic [7:0]         OPCODE;
  logic [4:0]         Ri;
  logic [ADDR_W-1:0]  ir_pc;

  logic [INSTR_W-1:0] mem [1024];
  exp_t sb[$];
  int   xfer_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   lat      = 1;
  int   cyc      = 0;
  int   xfer_cnt = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .dec_ready  (dec_ready),
    .ir_valid   (ir_valid),
    .OPCODE     (OPCODE),
    .Ri         (Ri),
    .ir_pc      (ir_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory: ack arrives lat cycles after the cycle in which imem_req is first seen.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (rst_n !== 1'b1) begin
        wait_cnt = 0;
      end else if (imem_req === 1'b1) begin
        if (wait_cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every ir_valid & dec_ready cycle must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && ir_valid === 1'b1 && dec_ready === 1'b1) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got opc=%h ri=%h pc=%h, expected no transfer", OPCODE, Ri, ir_pc);
        end else begin
          e = sb.pop_front();
          if ({OPCODE, Ri, ir_pc} !== e) begin
            failures++;
            $display("FAIL sb_xfer got opc=%h ri=%h pc=%h, expected opc=%h ri=%h pc=%h",
                     OPCODE, Ri, ir_pc, e.opc, e.ri, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    dec_ready = 1'b0;
    step();
    step();
    sb.delete();
    xfer_cyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    dec_ready = 1'b0;
    lat       = 1;
    step();
    checks++;
    if ({imem_req, imem_addr, ir_valid, OPCODE, Ri, ir_pc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b addr=%h vld=%b opc=%h ri=%h pc=%h, expected all 0",
               imem_req, imem_addr, ir_valid, OPCODE, Ri, ir_pc);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_req got %b, expected 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h, expected req=1 addr=000", imem_req, imem_addr);
    end
  endtask

  task automatic test_in_order();
    int n0;
    lat     = 1;
    mem[0]  = 16'h0C00;
    mem[1]  = 16'h0D01;
    mem[2]  = 16'h0400;
    do_reset();
    sb.push_back(exp_t'{8'h0C, 5'h00, 10'h000});
    sb.push_back(exp_t'{8'h0D, 5'h01, 10'h001});
    sb.push_back(exp_t'{8'h04, 5'h00, 10'h002});
    dec_ready = 1'b1;
    n0 = xfer_cnt;
    for (int i = 0; i < 60 && xfer_cnt < n0 + 3; i++) step();
    dec_ready = 1'b0;
    checks++;
    if (xfer_cnt != n0 + 3) begin
      failures++;
      $display("FAIL in_order_count got %0d, expected %0d", xfer_cnt - n0, 3);
    end
    checks++;
    if (xfer_cyc.size() < 3 || xfer_cyc[1] - xfer_cyc[0] != 3 || xfer_cyc[2] - xfer_cyc[1] != 3) begin
      failures++;
      $display("FAIL in_order_rate got spacing %0d/%0d cycles, expected 3/3",
               xfer_cyc.size() >= 2 ? xfer_cyc[1] - xfer_cyc[0] : -1,
               xfer_cyc.size() >= 3 ? xfer_cyc[2] - xfer_cyc[1] : -1);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL in_order_drain got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_stall();
    int n0;
    lat    = 1;
    mem[0] = 16'h1234;
    mem[1] = 16'h0000;
    do_reset();
    sb.push_back(exp_t'{8'h12, 5'h14, 10'h000});
    for (int i = 0; i < 20 && ir_valid !== 1'b1; i++) step();
    n0 = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ir_valid, imem_req, OPCODE, Ri, ir_pc} !== {1'b1, 1'b0, 8'h12, 5'h14, 10'h000}) begin
        failures++;
        $display("FAIL stall_hold cycle %0d got vld=%b req=%b opc=%h ri=%h pc=%h, expected vld=1 req=0 opc=12 ri=14 pc=000",
                 i, ir_valid, imem_req, OPCODE, Ri, ir_pc);
      end
      step();
    end
    checks++;
    if (xfer_cnt != n0) begin
      failures++;
      $display("FAIL stall_no_xfer got %0d transfers, expected 0", xfer_cnt - n0);
    end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (xfer_cnt != n0 + 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL stall_release got %0d transfers %0d pending, expected 1 transfer 0 pending",
               xfer_cnt - n0, sb.size());
    end
  endtask

  task automatic test_branch_drop();
    int n0;
    lat       = 2;
    mem[5]    = 16'hAAAA;
    mem[8'h20] = 16'h0E03;
    do_reset();
    sb.push_back(exp_t'{8'h0E, 5'h03, 10'h020});
    br_taken  = 1'b1;
    br_target = 10'h005;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h005) begin
      failures++;
      $display("FAIL idle_branch got req=%b addr=%h, expected req=1 addr=005", imem_req, imem_addr);
    end
    br_target = 10'h020;
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h005 || ir_valid !== 1'b0) begin
        failures++;
        $display("FAIL drop_hold cycle %0d got req=%b addr=%h vld=%b, expected req=1 addr=005 vld=0",
                 i, imem_req, imem_addr, ir_valid);
      end
      step();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h020 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_refetch got req=%b addr=%h vld=%b, expected req=1 addr=020 vld=0",
               imem_req, imem_addr, ir_valid);
    end
    dec_ready = 1'b1;
    n0 = xfer_cnt;
    for (int i = 0; i < 30 && xfer_cnt < n0 + 1; i++) step();
    dec_ready = 1'b0;
    checks++;
    if (xfer_cnt != n0 + 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL drop_result got %0d transfers %0d pending, expected 1 transfer 0 pending",
               xfer_cnt - n0, sb.size());
    end
  endtask

  task automatic test_branch_on_ack();
    int n0;
    lat        = 2;
    mem[0]     = 16'hBEEF;
    mem[8'h40] = 16'h0705;
    do_reset();
    sb.push_back(exp_t'{8'h07, 5'h05, 10'h040});
    dec_ready = 1'b1;
    for (int i = 0; i < 20 && imem_ack !== 1'b1; i++) step();
    br_taken  = 1'b1;
    br_target = 10'h040;
    step();
    br_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h040 || ir_valid !== 1'b0 || OPCODE !== 8'h00) begin
      failures++;
      $display("FAIL ack_branch got req=%b addr=%h vld=%b opc=%h, expected req=1 addr=040 vld=0 opc=00",
               imem_req, imem_addr, ir_valid, OPCODE);
    end
    n0 = xfer_cnt;
    for (int i = 0; i < 30 && xfer_cnt < n0 + 1; i++) step();
    dec_ready = 1'b0;
    checks++;
    if (xfer_cnt != n0 + 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL ack_branch_result got %0d transfers %0d pending, expected 1 transfer 0 pending",
               xfer_cnt - n0, sb.size());
    end
  endtask

  task automatic test_wrap();
    int n0;
    lat          = 1;
    mem[10'h3FF] = 16'h2211;
    mem[0]       = 16'h3302;
    do_reset();
    sb.push_back(exp_t'{8'h22, 5'h11, 10'h3FF});
    sb.push_back(exp_t'{8'h33, 5'h02, 10'h000});
    br_taken  = 1'b1;
    br_target = 10'h3FF;
    step();
    br_taken  = 1'b0;
    dec_ready = 1'b1;
    n0 = xfer_cnt;
    for (int i = 0; i < 40 && xfer_cnt < n0 + 2; i++) step();
    dec_ready = 1'b0;
    checks++;
    if (xfer_cnt != n0 + 2 || sb.size() != 0) begin
      failures++;
      $display("FAIL wrap_result got %0d transfers %0d pending, expected 2 transfers 0 pending",
               xfer_cnt - n0, sb.size());
    end
  endtask

  task automatic test_reset_mid_req();
    lat    = 1;
    mem[0] = 16'h5A3F;
    do_reset();
    sb.push_back(exp_t'{8'h5A, 5'h1F, 10'h000});
    for (int i = 0; i < 20 && ir_valid !== 1'b1; i++) step();
    lat       = 4;
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h001) begin
      failures++;
      $display("FAIL pre_reset_req got req=%b addr=%h, expected req=1 addr=001", imem_req, imem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, ir_valid, OPCODE, Ri, ir_pc, imem_addr} !== '0) begin
      failures++;
      $display("FAIL mid_req_reset got req=%b vld=%b opc=%h ri=%h pc=%h addr=%h, expected all 0",
               imem_req, ir_valid, OPCODE, Ri, ir_pc, imem_addr);
    end
    step();
    step();
    rst_n = 1'b1;
    lat   = 1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h000 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_req got req=%b addr=%h vld=%b, expected req=1 addr=000 vld=0",
               imem_req, imem_addr, ir_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL reset_drain got %0d pending, expected 0", sb.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    dec_ready = 1'b0;
    test_reset();
    test_in_order();
    test_stall();
    test_branch_drop();
    test_branch_on_ack();
    test_wrap();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
